ex_stage: RTL

Execute stage of the 16-bit pipelined processor. It sits directly downstream of the decode/execute pipeline register. It forwards operands from the EX/MEM and MEM/WB stages, runs the ALU, and holds the Z/V/N flag register. It also contains the EX/MEM pipeline register, so every output is registered and feeds the memory stage directly.

---
 rtl/ex_stage.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: operand forwarding, 16-bit ALU, Z/V/N flags, EX/MEM register
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        ALUSrc,
    input  logic [3:0]  ALUOp,
    input  logic [15:0] readData1,
    input  logic [15:0] readData2,
    input  logic [15:0] Immediate,
    input  logic [3:0]  Rs,
    input  logic [3:0]  Rt,
    input  logic [3:0]  Rd,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic        PCS,
    input  logic        HALT,
    input  logic [15:0] PC_Inc,
    input  logic        memwb_RegWrite,
    input  logic [3:0]  memwb_Rd,
    input  logic [15:0] memwb_WriteData,
    output logic [15:0] ALUResult_Out,
    output logic [15:0] StoreData_Out,
    output logic [3:0]  Rd_Out,
    output logic        MemRead_Out,
    output logic        MemWrite_Out,
    output logic        RegWrite_Out,
    output logic        MemtoReg_Out,
    output logic        PCS_Out,
    output logic        HALT_Out,
    output logic [15:0] PC_Inc_Out,
    output logic [2:0]  Flags
);

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LLB    = 4'b1010;
    localparam logic [3:0] OP_LHB    = 4'b1011;
    localparam logic [3:0] OP_PCS    = 4'b1110;

    logic [15:0] r_alu_result;
    logic [15:0] r_store_data;
    logic [3:0]  r_rd;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_reg_write;
    logic        r_mem_to_reg;
    logic        r_pcs;
    logic        r_halt;
    logic [15:0] r_pc_inc;
    logic [2:0]  r_flags;

    logic        w_exmem_valid;
    logic        w_memwb_valid;
    logic [15:0] w_op_a;
    logic [15:0] w_rt_val;
    logic [15:0] w_op_b;

    // EX/MEM only forwards ALU results; loads are kept out by the upstream hazard unit.
    assign w_exmem_valid = r_reg_write && !r_mem_to_reg && (r_rd != 4'd0);
    assign w_memwb_valid = memwb_RegWrite && (memwb_Rd != 4'd0);

    always_comb begin
        w_op_a = readData1;
        if (w_exmem_valid && (r_rd == Rs))
            w_op_a = r_alu_result;
        else if (w_memwb_valid && (memwb_Rd == Rs))
            w_op_a = memwb_WriteData;
    end

    always_comb begin
        w_rt_val = readData2;
        if (w_exmem_valid && (r_rd == Rt))
            w_rt_val = r_alu_result;
        else if (w_memwb_valid && (memwb_Rd == Rt))
            w_rt_val = memwb_WriteData;
    end

    assign w_op_b = ALUSrc ? Immediate : w_rt_val;

    logic [16:0] w_add_ext;
    logic [16:0] w_sub_ext;
    logic        w_add_ovf;
    logic        w_sub_ovf;
    logic [15:0] w_add_sat;
    logic [15:0] w_sub_sat;

    // 17-bit sign-extended sums: bits 16 and 15 disagree exactly on overflow.
    assign w_add_ext = {w_op_a[15], w_op_a} + {w_op_b[15], w_op_b};
    assign w_sub_ext = {w_op_a[15], w_op_a} - {w_op_b[15], w_op_b};
    assign w_add_ovf = w_add_ext[16] ^ w_add_ext[15];
    assign w_sub_ovf = w_sub_ext[16] ^ w_sub_ext[15];
    assign w_add_sat = w_add_ovf ? (w_add_ext[16] ? 16'h8000 : 16'h7FFF) : w_add_ext[15:0];
    assign w_sub_sat = w_sub_ovf ? (w_sub_ext[16] ? 16'h8000 : 16'h7FFF) : w_sub_ext[15:0];

    logic [8:0]  w_red_hi;
    logic [8:0]  w_red_lo;
    logic [9:0]  w_red_sum;

    assign w_red_hi  = {w_op_a[15], w_op_a[15:8]} + {w_op_b[15], w_op_b[15:8]};
    assign w_red_lo  = {w_op_a[7], w_op_a[7:0]} + {w_op_b[7], w_op_b[7:0]};
    assign w_red_sum = {w_red_hi[8], w_red_hi} + {w_red_lo[8], w_red_lo};

    logic [3:0]  w_shamt;
    logic [15:0] w_sll;
    logic [15:0] w_sra;
    logic [31:0] w_ror_wide;

    assign w_shamt    = Immediate[3:0];
    assign w_sll      = w_op_a << w_shamt;
    assign w_sra      = $signed(w_op_a) >>> w_shamt;
    assign w_ror_wide = {w_op_a, w_op_a} >> w_shamt;

    logic [15:0] w_paddsb;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_nib
            logic [4:0] w_nib_sum;
            assign w_nib_sum = {w_op_a[4*g+3], w_op_a[4*g +: 4]} + {w_op_b[4*g+3], w_op_b[4*g +: 4]};
            assign w_paddsb[4*g +: 4] = (w_nib_sum[4] ^ w_nib_sum[3]) ?
                                        (w_nib_sum[4] ? 4'h8 : 4'h7) : w_nib_sum[3:0];
        end
    endgenerate

    logic [15:0] w_result;
    logic        w_sat;
    logic        w_wr_z;
    logic        w_wr_vn;

    always_comb begin
        w_result = 16'h0000;
        w_sat    = 1'b0;
        w_wr_z   = 1'b0;
        w_wr_vn  = 1'b0;
        case (ALUOp)
            OP_ADD: begin
                w_result = w_add_sat;
                w_sat    = w_add_ovf;
                w_wr_z   = 1'b1;
                w_wr_vn  = 1'b1;
            end
            OP_SUB: begin
                w_result = w_sub_sat;
                w_sat    = w_sub_ovf;
                w_wr_z   = 1'b1;
                w_wr_vn  = 1'b1;
            end
            OP_XOR: begin
                w_result = w_op_a ^ w_op_b;
                w_wr_z   = 1'b1;
            end
            OP_RED:    w_result = {{6{w_red_sum[9]}}, w_red_sum};
            OP_SLL: begin
                w_result = w_sll;
                w_wr_z   = 1'b1;
            end
            OP_SRA: begin
                w_result = w_sra;
                w_wr_z   = 1'b1;
            end
            OP_ROR: begin
                w_result = w_ror_wide[15:0];
                w_wr_z   = 1'b1;
            end
            OP_PADDSB: w_result = w_paddsb;
            OP_LW, OP_SW: w_result = (w_op_a & 16'hFFFE) + Immediate;
            OP_LLB:    w_result = (w_op_a & 16'hFF00) | {8'h00, Immediate[7:0]};
            OP_LHB:    w_result = (w_op_a & 16'h00FF) | {Immediate[7:0], 8'h00};
            OP_PCS:    w_result = PC_Inc;
            default:   w_result = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_result <= 16'h0000;
            r_store_data <= 16'h0000;
            r_rd         <= 4'd0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_pcs        <= 1'b0;
            r_halt       <= 1'b0;
            r_pc_inc     <= 16'h0000;
            r_flags      <= 3'b000;
        end else if (!stall) begin
            r_alu_result <= w_result;
            r_store_data <= w_rt_val;
            r_rd         <= Rd;
            r_pc_inc     <= PC_Inc;
            r_mem_read   <= MemRead  && !flush;
            r_mem_write  <= MemWrite && !flush;
            r_reg_write  <= RegWrite && !flush;
            r_mem_to_reg <= MemtoReg && !flush;
            r_pcs        <= PCS      && !flush;
            r_halt       <= HALT     && !flush;
            // A flushed instruction is a bubble and must not disturb the flags.
            if (!flush) begin
                if (w_wr_z)
                    r_flags[2] <= (w_result == 16'h0000);
                if (w_wr_vn) begin
                    r_flags[1] <= w_sat;
                    r_flags[0] <= w_result[15];
                end
            end
        end
    end

    assign ALUResult_Out = r_alu_result;
    assign StoreData_Out = r_store_data;
    assign Rd_Out        = r_rd;
    assign MemRead_Out   = r_mem_read;
    assign MemWrite_Out  = r_mem_write;
    assign RegWrite_Out  = r_reg_write;
    assign MemtoReg_Out  = r_mem_to_reg;
    assign PCS_Out       = r_pcs;
    assign HALT_Out      = r_halt;
    assign PC_Inc_Out    = r_pc_inc;
    assign Flags         = r_flags;

endmodule
